// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with CTRL stall/flush handling and multi-cycle carry return.
// Optional perf counters are enabled by defining PIPE_STAGE_PERF_CNT_EN.
module pipe_stage_reg #(
  parameter int PAYLOAD_W = 110,
  parameter int CARRY_W   = 66,
  parameter int STALL_W   = 6,
  parameter int STAGE     = 3,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [CARRY_W-1:0]   carry_i,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CARRY_W-1:0]   carry_o,
  output logic [1:0]           state_o,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [CNT_W-1:0]     hold_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    VALID = 2'b01,
    HOLD  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_FLUSH,
    OP_BUBBLE,
    OP_ADVANCE,
    OP_HOLD
  } op_t;

  if (STAGE + 1 >= STALL_W) begin : g_bad_stage
    $error("pipe_stage_reg: STAGE+1 must be below STALL_W");
  end

  state_t                 state_q, state_d;
  logic [PAYLOAD_W-1:0]   payload_q, payload_d;
  logic [CARRY_W-1:0]     carry_q, carry_d;
  op_t                    op;
  logic                   stall_cur, stall_nxt;

  assign stall_cur = stall[STAGE];
  assign stall_nxt = stall[STAGE+1];

  // Resolve the stage action once; flush outranks every stall combination.
  always_comb begin
    if (flush)                       op = OP_FLUSH;
    else if (stall_cur && !stall_nxt) op = OP_BUBBLE;
    else if (!stall_cur)             op = OP_ADVANCE;
    else                             op = OP_HOLD;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    payload_d = payload_q;
    carry_d   = carry_q;
    unique case (op)
      OP_FLUSH: begin
        state_d   = EMPTY;
        payload_d = '0;
        carry_d   = '0;
      end
      OP_BUBBLE: begin
        state_d   = EMPTY;
        payload_d = '0;
        carry_d   = carry_i;
      end
      OP_ADVANCE: begin
        state_d   = in_valid ? VALID : EMPTY;
        payload_d = in_valid ? in_payload : '0;
        carry_d   = '0;
      end
      OP_HOLD: begin
        state_d = (state_q != EMPTY) ? HOLD : EMPTY;
        carry_d = carry_i;
      end
      default: ;
    endcase
  end

  // NOTE: the payload bank is reset too, because a squashed stage must read back as all zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      payload_q <= '0;
      carry_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all flops updating from the same pre-edge values.
      state_q   <= state_d;
      payload_q <= payload_d;
      carry_q   <= carry_d;
    end
  end

  // Valid is implied by occupancy, so it can never disagree with the payload.
  assign out_valid   = (state_q != EMPTY);
  assign out_payload = payload_q;
  assign carry_o     = carry_q;
  assign state_o     = state_q;

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [CNT_W-1:0] bubble_q, hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_q <= '0;
      hold_q   <= '0;
    end else begin
      if (op == OP_BUBBLE && bubble_q != '1) bubble_q <= bubble_q + 1'b1;
      if (op == OP_HOLD && hold_q != '1)     hold_q   <= hold_q + 1'b1;
    end
  end

  assign bubble_cnt = bubble_q;
  assign hold_cnt   = hold_q;
`else
  assign bubble_cnt = '0;
  assign hold_cnt   = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (out_valid || out_payload == '0)
        else $error("pipe_stage_reg: invalid slot carries a payload");
      assert (state_q != 2'b11)
        else $error("pipe_stage_reg: illegal state encoding");
    end
  end

endmodule
